// File: rtl/systolic_mm_engine.sv
// ---------------------------------------------------------------------------
// systolic_mm_engine
//
// Output-stationary N x N systolic matrix-multiply engine. One k-slice of
// operands (column k of A on west_i, row k of B on north_i) is accepted per
// beat. The engine skews the slices internally and PE(r,c) accumulates
// A[r][k]*B[k][c] into C_o[r][c]. Runtime inner dimension K, bubble tolerance,
// accumulate mode and signed/unsigned operands are supported.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start_i     job request, sampled only in IDLE
//   k_len_i     inner dimension K, latched with start_i
//   acc_mode_i  0: clear C at start, 1: accumulate onto held C
//   busy_o      high in FEED, DRAIN and DONE
//   in_valid_i  operand beat valid
//   in_ready_o  high only in FEED
//   west_i      west_i[r] = A[r][k]
//   north_i     north_i[c] = B[k][c]
//   C_o         C_o[r][c] accumulator, held between jobs
//   done_o      one-cycle pulse, C_o final
//   state_o     FSM state (IDLE=0, FEED=1, DRAIN=2, DONE=3)
//
// Handshake: a beat is transferred on every rising edge where in_valid_i and
// in_ready_o are both high; in_ready_o depends only on the FSM state, never on
// in_valid_i, and in_valid_i/operands are ignored whenever in_ready_o is low.
// ---------------------------------------------------------------------------
module systolic_mm_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 256,
    parameter int SIGNED = 1,
    localparam int KW    = $clog2(K_MAX + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [KW-1:0]                  k_len_i,
    input  logic                           acc_mode_i,
    output logic                           busy_o,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [N-1:0][DATA_W-1:0]       west_i,
    input  logic [N-1:0][DATA_W-1:0]       north_i,
    output logic [N-1:0][N-1:0][ACC_W-1:0] C_o,
    output logic                           done_o,
    output logic [1:0]                     state_o
);

    localparam int DCW = $clog2(2 * N);
    // The last PE accumulates the final slice 2N-1 edges after it is accepted.
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_len_q, k_len_d;
    logic [KW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           accept;
    logic           clear_c;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        accept      = 1'b0;
        clear_c     = 1'b0;
        busy_o      = 1'b1;
        in_ready_o  = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    k_len_d    = k_len_i;
                    beat_cnt_d = '0;
                    clear_c    = ~acc_mode_i;
                    state_d    = (k_len_i == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                in_ready_o = 1'b1;
                accept     = in_valid_i;
                if (in_valid_i) begin
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if (beat_cnt_d == k_len_q) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o = state_q;

    // ---------------------------------------------------------- input skew
    // Row/column i passes through a chain of i+1 registers; stage 0 captures
    // the beat on its acceptance edge. Cycles without an accepted beat shift
    // in a tag=0 bubble.
    logic [N-1:0][DATA_W-1:0] row_dat, col_dat;
    logic [N-1:0]             row_tag, col_tag;

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W-1:0] w_dat_q [0:i];
        logic [DATA_W-1:0] w_dat_d [0:i];
        logic [DATA_W-1:0] n_dat_q [0:i];
        logic [DATA_W-1:0] n_dat_d [0:i];
        logic [i:0]        w_tag_q, w_tag_d;
        logic [i:0]        n_tag_q, n_tag_d;

        always_comb begin
            w_tag_d    = '0;
            n_tag_d    = '0;
            w_dat_d[0] = accept ? west_i[i] : w_dat_q[0];
            n_dat_d[0] = accept ? north_i[i] : n_dat_q[0];
            w_tag_d[0] = accept;
            n_tag_d[0] = accept;
            for (int j = 1; j <= i; j++) begin
                w_dat_d[j] = w_dat_q[j-1];
                n_dat_d[j] = n_dat_q[j-1];
                w_tag_d[j] = w_tag_q[j-1];
                n_tag_d[j] = n_tag_q[j-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= i; j++) begin
                    w_dat_q[j] <= '0;
                    n_dat_q[j] <= '0;
                end
                w_tag_q <= '0;
                n_tag_q <= '0;
            end else begin
                w_dat_q <= w_dat_d;
                n_dat_q <= n_dat_d;
                w_tag_q <= w_tag_d;
                n_tag_q <= n_tag_d;
            end
        end

        assign row_dat[i] = w_dat_q[i];
        assign row_tag[i] = w_tag_q[i];
        assign col_dat[i] = n_dat_q[i];
        assign col_tag[i] = n_tag_q[i];
    end

    // ------------------------------------------------------------ PE array
    // Only PEs with an east/south neighbour keep a forwarding register.
    logic [N-1:0][N-2:0][DATA_W-1:0] pe_w_dat;
    logic [N-1:0][N-2:0]             pe_w_tag;
    logic [N-2:0][N-1:0][DATA_W-1:0] pe_n_dat;
    logic [N-2:0][N-1:0]             pe_n_tag;

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_pe
            logic [DATA_W-1:0]   a_in, b_in;
            logic                a_tag, b_tag;
            logic [2*DATA_W-1:0] a_ext, b_ext, prod;
            logic [ACC_W-1:0]    prod_ext;
            logic [ACC_W-1:0]    acc_q, acc_d;

            if (c == 0) begin : g_w_edge
                assign a_in  = row_dat[r];
                assign a_tag = row_tag[r];
            end else begin : g_w_link
                assign a_in  = pe_w_dat[r][c-1];
                assign a_tag = pe_w_tag[r][c-1];
            end

            if (r == 0) begin : g_n_edge
                assign b_in  = col_dat[c];
                assign b_tag = col_tag[c];
            end else begin : g_n_link
                assign b_in  = pe_n_dat[r-1][c];
                assign b_tag = pe_n_tag[r-1][c];
            end

            if (c < N - 1) begin : g_w_reg
                logic [DATA_W-1:0] dat_q, dat_d;
                logic              tag_q, tag_d;
                always_comb begin
                    dat_d = a_in;
                    tag_d = a_tag;
                end
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        dat_q <= '0;
                        tag_q <= 1'b0;
                    end else begin
                        dat_q <= dat_d;
                        tag_q <= tag_d;
                    end
                end
                assign pe_w_dat[r][c] = dat_q;
                assign pe_w_tag[r][c] = tag_q;
            end

            if (r < N - 1) begin : g_n_reg
                logic [DATA_W-1:0] dat_q, dat_d;
                logic              tag_q, tag_d;
                always_comb begin
                    dat_d = b_in;
                    tag_d = b_tag;
                end
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        dat_q <= '0;
                        tag_q <= 1'b0;
                    end else begin
                        dat_q <= dat_d;
                        tag_q <= tag_d;
                    end
                end
                assign pe_n_dat[r][c] = dat_q;
                assign pe_n_tag[r][c] = tag_q;
            end

            // Operands are extended to 2*DATA_W first, so the low 2*DATA_W bits
            // of the unsigned multiply are the exact product in either mode.
            always_comb begin
                a_ext    = (SIGNED != 0) ? {{DATA_W{a_in[DATA_W-1]}}, a_in}
                                         : {{DATA_W{1'b0}}, a_in};
                b_ext    = (SIGNED != 0) ? {{DATA_W{b_in[DATA_W-1]}}, b_in}
                                         : {{DATA_W{1'b0}}, b_in};
                prod     = a_ext * b_ext;
                prod_ext = {{(ACC_W - 2*DATA_W){(SIGNED != 0) & prod[2*DATA_W-1]}}, prod};
                acc_d    = acc_q;
                if (clear_c) begin
                    acc_d = '0;
                end else if (a_tag & b_tag) begin
                    acc_d = acc_q + prod_ext;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign C_o[r][c] = acc_q;
        end
    end

endmodule
